// File: rtl/header_detect_pkg.sv
// Shared types and default constants for the RX preamble detector.
// The FSM state enum and the default header bytes and pair count live here.
package header_detect_pkg;

    // Detector FSM: expecting the first or the second byte of a pair
    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

    localparam logic [7:0] HDR_A     = 8'h55;
    localparam logic [7:0] HDR_B     = 8'hD5;
    localparam int         HDR_PAIRS = 5;

endpackage

// File: rtl/header_detect.sv
// header_detect: byte-stream preamble detector.
// It looks for PAIRS consecutive {A_BYTE, B_BYTE} pairs and pulses hdr_found
// for one cycle when the header completes.
// Optional macro HEADER_DETECT_LOCK_EN adds a sticky hdr_lock output. That flag
// sets with the first hdr_found and is cleared only by reset.
module header_detect
    import header_detect_pkg::*;
#(
    parameter int          DW     = 8,
    parameter logic [DW-1:0] A_BYTE = DW'(HDR_A),
    parameter logic [DW-1:0] B_BYTE = DW'(HDR_B),
    parameter int          PAIRS  = HDR_PAIRS,
    parameter int          CNT_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    din,
    output logic             hdr_found,
    output logic [CNT_W-1:0] pair_cnt
`ifdef HEADER_DETECT_LOCK_EN
    ,
    output logic             hdr_lock
`endif
);

    // The final pair index. Completing this pair completes the header.
    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(PAIRS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt1_d;
    logic             hdr_found_q, hdr_found_d;

    // Next-state logic. Any byte that does not continue the run clears the pair count.
    always_comb begin
        state_d     = state_q;
        cnt1_d      = cnt1;
        hdr_found_d = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (din == A_BYTE) begin
                    state_d = WAIT_B;
                end else begin
                    cnt1_d = '0;
                end
            end
            WAIT_B: begin
                if (din == B_BYTE) begin
                    state_d = WAIT_A;
                    if (cnt1 == LAST_PAIR) begin
                        hdr_found_d = 1'b1;
                        cnt1_d      = '0;
                    end else begin
                        cnt1_d = cnt1 + CNT_W'(1);
                    end
                end else if (din == A_BYTE) begin
                    // A repeated A byte starts a fresh pair. Its B byte is still expected.
                    cnt1_d = '0;
                end else begin
                    cnt1_d  = '0;
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
                cnt1_d  = '0;
            end
        endcase
    end

    // State, pair count and found-pulse registers. Reset overrides every transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_A;
            cnt1        <= '0;
            hdr_found_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt1        <= cnt1_d;
            hdr_found_q <= hdr_found_d;
        end
    end

    assign hdr_found = hdr_found_q;
    assign pair_cnt  = cnt1;

`ifdef HEADER_DETECT_LOCK_EN
    logic hdr_lock_q;

    // Sticky lock flag. It sets in the same cycle as the first hdr_found and holds until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_lock_q <= 1'b0;
        end else if (hdr_found_d) begin
            hdr_lock_q <= 1'b1;
        end
    end

    assign hdr_lock = hdr_lock_q;
`endif

endmodule

// File: tb/tb_header_detect.sv
// Self-checking bench for header_detect.
// A table of {rst_n, din, expected count, expected pulse} vectors is applied first.
// Hand-written sequences then cover reset in the middle of a run and the lock flag.
// The lock checks are built only when HEADER_DETECT_LOCK_EN is defined.
module tb_header_detect;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       hdr_found;
    logic [2:0] pair_cnt;
`ifdef HEADER_DETECT_LOCK_EN
    logic       hdr_lock;
`endif

    int errors = 0;
    int checks = 0;

    header_detect dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .hdr_found (hdr_found),
        .pair_cnt  (pair_cnt)
`ifdef HEADER_DETECT_LOCK_EN
        ,
        .hdr_lock  (hdr_lock)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [7:0] din;
        logic [2:0] exp_cnt;
        logic       exp_found;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [7:0] d,
                                input logic [2:0] c, input logic f, input string t);
        vec_t v;
        v.rst_n = r; v.din = d; v.exp_cnt = c; v.exp_found = f; v.tag = t;
        vecs.push_back(v);
    endfunction

    // Drive one byte, clock it in, and settle just past the edge before sampling.
    task automatic step(input logic r, input logic [7:0] d);
        rst_n = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int pulses;
    int c;

    initial begin
        rst_n = 1'b0;
        din   = 8'h00;

        // Test 1: reset, idle, then a single full header
        for (int i = 0; i < 3; i++)  add(1'b0, 8'h00, 3'd0, 1'b0, "t1_reset");
        for (int i = 0; i < 10; i++) add(1'b1, 8'h00, 3'd0, 1'b0, "t1_idle");
        add(1'b1, 8'h55, 3'd0, 1'b0, "t1_a1"); add(1'b1, 8'hD5, 3'd1, 1'b0, "t1_b1");
        add(1'b1, 8'h55, 3'd1, 1'b0, "t1_a2"); add(1'b1, 8'hD5, 3'd2, 1'b0, "t1_b2");
        add(1'b1, 8'h55, 3'd2, 1'b0, "t1_a3"); add(1'b1, 8'hD5, 3'd3, 1'b0, "t1_b3");
        add(1'b1, 8'h55, 3'd3, 1'b0, "t1_a4"); add(1'b1, 8'hD5, 3'd4, 1'b0, "t1_b4");
        add(1'b1, 8'h55, 3'd4, 1'b0, "t1_a5"); add(1'b1, 8'hD5, 3'd0, 1'b1, "t1_b5_pulse");
        // Test 2: idle, then a short run that breaks off
        add(1'b1, 8'h00, 3'd0, 1'b0, "t2_idle1"); add(1'b1, 8'h00, 3'd0, 1'b0, "t2_idle2");
        add(1'b1, 8'h55, 3'd0, 1'b0, "t2_a1"); add(1'b1, 8'hD5, 3'd1, 1'b0, "t2_b1");
        add(1'b1, 8'h55, 3'd1, 1'b0, "t2_a2"); add(1'b1, 8'hD5, 3'd2, 1'b0, "t2_b2");
        add(1'b1, 8'h00, 3'd0, 1'b0, "t2_break");
        // Test 3: near-miss bytes never count
        for (int i = 0; i < 3; i++) begin
            add(1'b1, 8'h56, 3'd0, 1'b0, "t3_56");
            add(1'b1, 8'hD6, 3'd0, 1'b0, "t3_D6");
        end
        // Test 4: ten back-to-back pairs give two pulses
        c = 0;
        for (int p = 0; p < 10; p++) begin
            add(1'b1, 8'h55, 3'(c), 1'b0, "t4_a");
            if (c == 4) begin
                c = 0;
                add(1'b1, 8'hD5, 3'd0, 1'b1, "t4_b_pulse");
            end else begin
                c++;
                add(1'b1, 8'hD5, 3'(c), 1'b0, "t4_b");
            end
        end
        // Test 5: a repeated 55 restarts the count
        add(1'b1, 8'h55, 3'd0, 1'b0, "t5_a1"); add(1'b1, 8'hD5, 3'd1, 1'b0, "t5_b1");
        add(1'b1, 8'h55, 3'd1, 1'b0, "t5_a2"); add(1'b1, 8'hD5, 3'd2, 1'b0, "t5_b2");
        add(1'b1, 8'h55, 3'd2, 1'b0, "t5_a3"); add(1'b1, 8'hD5, 3'd3, 1'b0, "t5_b3");
        add(1'b1, 8'h55, 3'd3, 1'b0, "t5_a4"); add(1'b1, 8'h55, 3'd0, 1'b0, "t5_rep_a");
        add(1'b1, 8'hD5, 3'd1, 1'b0, "t5_b_after_rep"); add(1'b1, 8'h00, 3'd0, 1'b0, "t5_end");

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].din);
            $display("vec %0d %s rst_n=%0b din=%02h cnt=%0d found=%0b",
                     i, vecs[i].tag, vecs[i].rst_n, vecs[i].din, pair_cnt, hdr_found);
            check({vecs[i].tag, "_cnt"},   8'(pair_cnt),  8'(vecs[i].exp_cnt));
            check({vecs[i].tag, "_cnt1"},  8'(dut.cnt1),  8'(vecs[i].exp_cnt));
            check({vecs[i].tag, "_found"}, 8'(hdr_found), 8'(vecs[i].exp_found));
        end

`ifdef HEADER_DETECT_LOCK_EN
        check("lock_after_runs", 8'(hdr_lock), 8'd1);
`endif

        // Test 6: reset while cnt1=3, then a full header still detects once
        for (int p = 0; p < 3; p++) begin
            step(1'b1, 8'h55);
            step(1'b1, 8'hD5);
        end
        $display("seq t6 pre-reset cnt1=%0d", dut.cnt1);
        check("t6_cnt_before_reset", 8'(dut.cnt1), 8'd3);
        step(1'b0, 8'h55);
        $display("seq t6 reset cnt1=%0d found=%0b", dut.cnt1, hdr_found);
        check("t6_cnt_after_reset", 8'(dut.cnt1), 8'd0);
        check("t6_found_after_reset", 8'(hdr_found), 8'd0);
`ifdef HEADER_DETECT_LOCK_EN
        check("t6_lock_after_reset", 8'(hdr_lock), 8'd0);
`endif
        pulses = 0;
        for (int p = 0; p < 5; p++) begin
            step(1'b1, 8'h55);
            if (hdr_found) pulses++;
            step(1'b1, 8'hD5);
            if (hdr_found) pulses++;
        end
        check("t6_found_at_10th", 8'(hdr_found), 8'd1);
        // The pulse must last only one cycle. Also feed garbage, which the lock must ignore.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h12);
            if (hdr_found) pulses++;
        end
        $display("seq t6 header pulses=%0d", pulses);
        check("t6_pulse_count", 8'(pulses), 8'd1);
`ifdef HEADER_DETECT_LOCK_EN
        check("t6_lock_held", 8'(hdr_lock), 8'd1);
`endif

        // Reset asserted on the edge that samples the final D5 wins over the pulse
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 8'h55);
            step(1'b1, 8'hD5);
        end
        check("prio_cnt_before", 8'(dut.cnt1), 8'd4);
        step(1'b1, 8'h55);
        step(1'b0, 8'hD5);
        $display("seq prio reset-on-last found=%0b cnt1=%0d", hdr_found, dut.cnt1);
        check("prio_found", 8'(hdr_found), 8'd0);
        check("prio_cnt", 8'(dut.cnt1), 8'd0);
`ifdef HEADER_DETECT_LOCK_EN
        check("prio_lock", 8'(hdr_lock), 8'd0);
`endif
        step(1'b1, 8'h00);
        check("prio_found_after", 8'(hdr_found), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
